// File: rtl/sdram_aref_credit.sv
// sdram_aref_credit: SDRAM auto-refresh engine with a postponed-refresh debt counter; define AREF_DEBT_FLUSH_EN to service the whole debt latched at the grant
module sdram_aref_credit #(
  parameter int REF_INTERVAL = 780,
  parameter int AR_PER_REQ   = 2,
  parameter int TRP_CYC      = 2,
  parameter int TRFC_CYC     = 7,
  parameter int MAX_DEBT     = 8,
  parameter int URGENT_LVL   = 4,
  parameter int BANK_W       = 2,
  parameter int ADDR_W       = 13
) (
  input  logic              ar_clk,
  input  logic              ar_rst_n,
  input  logic              init_end,
  input  logic              ar_en,
  output logic              ar_req,
  output logic              ar_urgent,
  output logic              ar_end,
  output logic [3:0]        ar_cmd,
  output logic [BANK_W-1:0] ar_bank,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [3:0]        ar_debt,
  output logic              ar_ovf
);
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_AR  = 4'b0001;
  localparam int CW = REF_INTERVAL > 1 ? $clog2(REF_INTERVAL) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_TRP, S_AR, S_TRFC, S_END} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    debt_q, debt_d, wait_q, wait_d, cmd_q, cmd_d, svc, rem;
  logic [7:0]    arc_q, arc_d, target;
  logic          ovf_q, ovf_d, tick, done, grant;

  assign tick  = init_end && cnt_q == CW'(REF_INTERVAL - 1);
  assign done  = state_q == S_END;
  assign grant = ar_req && ar_en;
  assign rem   = done ? (debt_q >= svc ? debt_q - svc : 4'd0) : debt_q;

`ifdef AREF_DEBT_FLUSH_EN
  logic [3:0] lat_q, lat_d;
  assign svc    = lat_q;
  assign target = 8'(lat_q * AR_PER_REQ);
  // debt snapshot taken at the grant sets both the AR count and the END decrement
  always_comb lat_d = grant ? debt_q : lat_q;
  // snapshot register
  always_ff @(posedge ar_clk or negedge ar_rst_n)
    if (!ar_rst_n) lat_q <= 4'd0;
    else lat_q <= lat_d;
`else
  assign svc    = 4'd1;
  assign target = 8'(AR_PER_REQ);
`endif

  // next-state logic: PRE, TRP wait, then AR/TRFC pairs until the AR target is met
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant) state_d = S_PRE;
      S_PRE:   state_d = S_TRP;
      S_TRP:   if (wait_q == 4'(TRP_CYC - 1)) state_d = S_AR;
      S_AR:    state_d = S_TRFC;
      S_TRFC:  if (wait_q == 4'(TRFC_CYC - 1)) state_d = arc_q < target ? S_AR : S_END;
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // interval counter, saturating debt with sticky overflow, wait/AR counters, command decode
  always_comb begin
    cnt_d  = (!init_end || tick) ? '0 : cnt_q + CW'(1);
    debt_d = !init_end ? 4'd0 : (tick && rem == 4'(MAX_DEBT)) ? rem : rem + {3'd0, tick};
    ovf_d  = ovf_q | (tick && rem == 4'(MAX_DEBT));
    wait_d = ((state_q == S_TRP || state_q == S_TRFC) && state_d == state_q) ? wait_q + 4'd1 : 4'd0;
    arc_d  = done ? 8'd0 : state_q == S_AR ? arc_q + 8'd1 : arc_q;
    cmd_d  = state_q == S_PRE ? CMD_PRE : state_q == S_AR ? CMD_AR : CMD_NOP;
  end

  // FSM state register
  always_ff @(posedge ar_clk or negedge ar_rst_n)
    if (!ar_rst_n) state_q <= S_IDLE;
    else state_q <= state_d;

  // datapath registers; the command bus lags the state by one cycle
  always_ff @(posedge ar_clk or negedge ar_rst_n) begin
    if (!ar_rst_n) begin
      cnt_q  <= '0;
      debt_q <= 4'd0;
      ovf_q  <= 1'b0;
      wait_q <= 4'd0;
      arc_q  <= 8'd0;
      cmd_q  <= CMD_NOP;
    end else begin
      cnt_q  <= cnt_d;
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
      wait_q <= wait_d;
      arc_q  <= arc_d;
      cmd_q  <= cmd_d;
    end
  end

  assign ar_req    = init_end && state_q == S_IDLE && debt_q != 4'd0;
  assign ar_urgent = debt_q >= 4'(URGENT_LVL);
  assign ar_end    = done;
  assign ar_cmd    = cmd_q;
  assign ar_bank   = {BANK_W{1'b1}};
  assign ar_addr   = {ADDR_W{1'b1}};
  assign ar_debt   = debt_q;
  assign ar_ovf    = ovf_q;
endmodule

// File: tb/tb_sdram_aref_credit.sv
// tb_sdram_aref_credit: vector table, corner sequences and randomized run against a timeline reference model
module tb_sdram_aref_credit;
  localparam int REF = 780, NAR = 2, TRP = 2, TRFC = 7, MAXD = 8, URG = 4;
`ifdef AREF_DEBT_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif
  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, ARC = 4'b0001;

  logic ar_clk = 1'b0, ar_rst_n = 1'b0, init_end = 1'b0, ar_en = 1'b0;
  logic ar_req, ar_urgent, ar_end, ar_ovf;
  logic [3:0] ar_cmd, ar_debt;
  logic [1:0] ar_bank;
  logic [12:0] ar_addr;

  int total = 0, bad = 0, cyc = 0;
  int m_debt, m_icnt, m_g, m_d, m_n;
  logic m_ovf;

  typedef struct {
    int len;
    logic en;
    logic [3:0] cmd, debt;
    logic req, urg, endp, ovf;
  } vec_t;
  vec_t tv[21];

  sdram_aref_credit #(
    .REF_INTERVAL(REF), .AR_PER_REQ(NAR), .TRP_CYC(TRP), .TRFC_CYC(TRFC),
    .MAX_DEBT(MAXD), .URGENT_LVL(URG), .BANK_W(2), .ADDR_W(13)
  ) dut (
    .ar_clk(ar_clk), .ar_rst_n(ar_rst_n), .init_end(init_end), .ar_en(ar_en),
    .ar_req(ar_req), .ar_urgent(ar_urgent), .ar_end(ar_end), .ar_cmd(ar_cmd),
    .ar_bank(ar_bank), .ar_addr(ar_addr), .ar_debt(ar_debt), .ar_ovf(ar_ovf)
  );

  always #5 ar_clk = ~ar_clk;

  function automatic vec_t v(int len, logic en, logic [3:0] cmd, logic [3:0] debt, logic req, logic urg, logic endp, logic ovf);
    vec_t r;
    r.len = len; r.en = en; r.cmd = cmd; r.debt = debt;
    r.req = req; r.urg = urg; r.endp = endp; r.ovf = ovf;
    return r;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic m_reset();
    m_debt = 0; m_icnt = 0; m_ovf = 1'b0;
    m_g = -100000; m_d = 1; m_n = NAR; cyc = 0;
  endtask

  task automatic do_reset();
    ar_rst_n = 1'b0; ar_en = 1'b0;
    repeat (2) @(negedge ar_clk);
    ar_rst_n = 1'b1;
    m_reset();
  endtask

  // one clock: compare outputs with the timeline model, advance the model with this cycle's inputs
  task automatic step();
    int off, ls, k, od;
    logic [3:0] ec;
    logic ee, ei, er, eu, tk;
    #1;
    off = cyc - m_g;
    ls = 2 + TRP + m_n * (1 + TRFC);
    k = off - 3 - TRP;
    ec = off == 2 ? PRE : (k >= 0 && k % (1 + TRFC) == 0 && k / (1 + TRFC) < m_n) ? ARC : NOP;
    ee = off == ls;
    ei = off < 1 || off > ls;
    er = init_end && ei && m_debt != 0;
    eu = m_debt >= URG;
    check("cycle", {ar_cmd, ar_end, ar_req, ar_urgent, ar_debt, ar_ovf, ar_bank, ar_addr},
          {ec, ee, er, eu, 4'(m_debt), m_ovf, 15'h7fff});
    tk = init_end && m_icnt == REF - 1;
    od = m_debt;
    if (!init_end) m_debt = 0;
    else begin
      m_debt = m_debt - (ee ? (m_d < m_debt ? m_d : m_debt) : 0) + (tk ? 1 : 0);
      if (m_debt > MAXD) begin m_debt = MAXD; m_ovf = 1'b1; end
    end
    m_icnt = (init_end && !tk) ? m_icnt + 1 : 0;
    if (er && ar_en) begin m_g = cyc; m_d = FLUSH ? od : 1; m_n = NAR * m_d; end
    cyc++;
    @(negedge ar_clk);
  endtask

  task automatic run_to(int c);
    while (cyc < c) step();
  endtask

  initial begin
    int g, npre, nar, first, last, exp_ar, thr;
    tv[0]  = v(1,    0, NOP, 0, 0, 0, 0, 0);
    tv[1]  = v(779,  0, NOP, 0, 0, 0, 0, 0);
    tv[2]  = v(1,    0, NOP, 1, 1, 0, 0, 0);
    tv[3]  = v(1,    1, NOP, 1, 1, 0, 0, 0);
    tv[4]  = v(1,    0, NOP, 1, 0, 0, 0, 0);
    tv[5]  = v(1,    0, PRE, 1, 0, 0, 0, 0);
    tv[6]  = v(2,    0, NOP, 1, 0, 0, 0, 0);
    tv[7]  = v(1,    0, ARC, 1, 0, 0, 0, 0);
    tv[8]  = v(7,    0, NOP, 1, 0, 0, 0, 0);
    tv[9]  = v(1,    0, ARC, 1, 0, 0, 0, 0);
    tv[10] = v(7,    0, NOP, 1, 0, 0, 1, 0);
    tv[11] = v(1,    0, NOP, 0, 0, 0, 0, 0);
    tv[12] = v(757,  0, NOP, 0, 0, 0, 0, 0);
    tv[13] = v(1,    0, NOP, 1, 1, 0, 0, 0);
    tv[14] = v(2339, 0, NOP, 3, 1, 0, 0, 0);
    tv[15] = v(1,    0, NOP, 4, 1, 1, 0, 0);
    tv[16] = v(3119, 0, NOP, 7, 1, 1, 0, 0);
    tv[17] = v(1,    0, NOP, 8, 1, 1, 0, 0);
    tv[18] = v(779,  0, NOP, 8, 1, 1, 0, 0);
    tv[19] = v(1,    0, NOP, 8, 1, 1, 0, 1);
    tv[20] = v(780,  0, NOP, 8, 1, 1, 0, 1);

    init_end = 1'b1;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      ar_en = tv[i].en;
      repeat (tv[i].len - 1) step();
      #1;
      check($sformatf("vec%0d", i), {ar_cmd, ar_debt, ar_req, ar_urgent, ar_end, ar_ovf},
            {tv[i].cmd, tv[i].debt, tv[i].req, tv[i].urg, tv[i].endp, tv[i].ovf});
      step();
    end

    // END lands on a tick: debt unchanged, request back the next cycle
    do_reset();
    run_to(1539);
    ar_en = 1'b1; step(); ar_en = 1'b0;
    run_to(1559);
    #1;
    check("endtick_end", ar_end, 1);
    check("endtick_debt", ar_debt, 1);
    step();
    #1;
    check("after_end_debt", ar_debt, 1);
    check("after_end_req", ar_req, 1);
    step();

    // asynchronous reset while the AR command is on the bus
    do_reset();
    run_to(780);
    ar_en = 1'b1; step(); ar_en = 1'b0;
    run_to(785);
    #2;
    check("pre_rst_cmd", ar_cmd, ARC);
    ar_rst_n = 1'b0;
    #1;
    check("rst_cmd", ar_cmd, NOP);
    check("rst_debt", ar_debt, 0);
    check("rst_flags", {ar_req, ar_end, ar_urgent, ar_ovf}, 0);
    do_reset();
    ar_en = 1'b1;
    nar = 0;
    while (cyc < 700) begin
      if (ar_cmd == ARC) nar++;
      step();
    end
    check("no_ar_after_rst", nar, 0);
    ar_en = 1'b0;

    // grant with debt 3: one unit per grant, or the whole debt when flushing
    do_reset();
    run_to(2340);
    #1;
    check("seq_debt_before", ar_debt, 3);
    g = cyc;
    ar_en = 1'b1; step(); ar_en = 1'b0;
    npre = 0; nar = 0; first = -1; last = -1;
    exp_ar = FLUSH ? 3 * NAR : NAR;
    while (cyc < g + 60) begin
      if (ar_cmd == PRE) npre++;
      if (ar_cmd == ARC) begin nar++; if (first < 0) first = cyc; last = cyc; end
      step();
    end
    check("seq_pre", npre, 1);
    check("seq_ar", nar, exp_ar);
    check("seq_first_ar", first - g, 5);
    check("seq_span", last - first, (exp_ar - 1) * (1 + TRFC));
    #1;
    check("seq_debt_after", ar_debt, FLUSH ? 0 : 2);
    step();

    // randomized grants with varying pressure and occasional init_end drops
    do_reset();
    init_end = 1'b1;
    for (int b = 0; b < 15; b++) begin
      thr = b % 4 == 0 ? 0 : b % 4 == 1 ? 2 : b % 4 == 2 ? 10 : 50;
      if (!init_end && $urandom_range(0, 1) == 1) init_end = 1'b1;
      for (int c = 0; c < 2000; c++) begin
        ar_en = $urandom_range(0, 99) < thr;
        if ($urandom_range(0, 1999) == 0) init_end = !init_end;
        step();
      end
    end
    ar_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
